// File: rtl/paddle_ctrl.sv
// paddle_ctrl: turns debounced up/down presses into queued paddle travel, one pixel per frame tick.
// Optional PADDLE_WRAP_EN: the paddle wraps at the screen limits instead of stopping there.
module paddle_ctrl #(
    parameter int Y_W      = 10,
    parameter int SCREEN_H = 480,
    parameter int PADDLE_H = 64,
    parameter int STEP     = 16,
    parameter int MAX_PEND = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           up_pulse,
    input  logic           down_pulse,
    input  logic           frame_tick,
    input  logic           recenter,
    output logic [Y_W-1:0] paddle_y,
    output logic           moving,
    output logic           at_top,
    output logic           at_bottom
);
    localparam int Y_MAX  = SCREEN_H - PADDLE_H;
    localparam int CENTER = Y_MAX / 2;
    localparam int P_W    = $clog2(MAX_PEND + 1);
`ifdef PADDLE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN} state_t;

    state_t         state, state_n;
    logic [Y_W-1:0] y_n;
    logic [P_W-1:0] pend, pend_n, pend_sat;
    logic [P_W:0]   pend_sum;
    logic           up_ok, dn_ok, lim;

    assign at_top    = paddle_y == '0;
    assign at_bottom = paddle_y == Y_W'(Y_MAX);
    assign moving    = state != IDLE;

    // A press at the limit it would push against is ignored unless wrapping
    assign up_ok    = up_pulse & ~down_pulse & (WRAP | ~at_top);
    assign dn_ok    = down_pulse & ~up_pulse & (WRAP | ~at_bottom);
    assign pend_sum = {1'b0, pend} + (P_W+1)'(STEP);
    assign pend_sat = (pend_sum > (P_W+1)'(MAX_PEND)) ? P_W'(MAX_PEND) : pend_sum[P_W-1:0];
    assign lim      = (state == MOVE_UP) ? at_top : at_bottom;

    always_comb begin
        state_n = state;
        y_n     = paddle_y;
        pend_n  = pend;
        if (recenter) begin
            state_n = IDLE;
            y_n     = Y_W'(CENTER);
            pend_n  = '0;
        end else if (up_ok) begin
            pend_n  = (state == MOVE_DOWN) ? P_W'(STEP) : pend_sat;
            state_n = MOVE_UP;
        end else if (dn_ok) begin
            pend_n  = (state == MOVE_UP) ? P_W'(STEP) : pend_sat;
            state_n = MOVE_DOWN;
        end else if (frame_tick && state != IDLE) begin
            // Move states always hold pend >= 1, so pend == 1 means this tick finishes the travel
            if (lim) begin
                y_n     = WRAP ? ((state == MOVE_UP) ? Y_W'(Y_MAX) : '0) : paddle_y;
                pend_n  = WRAP ? pend - 1'b1 : '0;
                state_n = (!WRAP || pend == P_W'(1)) ? IDLE : state;
            end else begin
                y_n     = (state == MOVE_UP) ? paddle_y - 1'b1 : paddle_y + 1'b1;
                pend_n  = pend - 1'b1;
                state_n = (pend == P_W'(1)) ? IDLE : state;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            paddle_y <= Y_W'(CENTER);
            pend     <= '0;
        end else begin
            state    <= state_n;
            paddle_y <= y_n;
            pend     <= pend_n;
        end
    end
endmodule
